// File: rtl/dl_cycle_tracer.sv
// Deadlock detector and wait-for cycle/chain walker; streams one record per blocked process.
// Optional `DL_TRACE_TIMESTAMP_EN adds o_rec_time, the free-running cycle count at detection.
`timescale 1ns/1ps
module dl_cycle_tracer #(
  parameter int PROC_NUM     = 4,
  parameter int STALL_THRESH = 16,
  parameter int CYC_W        = 8,
  localparam int IDX_W       = $clog2(PROC_NUM)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [PROC_NUM-1:0]          i_blocked_vec,
  input  logic [PROC_NUM*PROC_NUM-1:0] i_wait_for,
  input  logic                         i_dl_clear,
  output logic                         o_dl_detect,
  output logic                         o_rec_valid,
  input  logic                         i_rec_ready,
  output logic [CYC_W-1:0]             o_rec_cycle_id,
  output logic [IDX_W-1:0]             o_rec_proc_idx,
  output logic                         o_rec_last,
  output logic [1:0]                   o_rec_term,
`ifdef DL_TRACE_TIMESTAMP_EN
  output logic [31:0]                  o_rec_time,
`endif
  output logic                         o_report_done
);
  localparam int CNT_W = $clog2(STALL_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STALL_THRESH - 1);
  localparam logic [IDX_W-1:0] STEP_LAST = IDX_W'(PROC_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EMIT, S_DONE} state_t;

  state_t r_state, w_nstate;
  logic [PROC_NUM-1:0]                r_prev_b, r_snap_b, r_done;
  logic [PROC_NUM-1:0][PROC_NUM-1:0]  r_snap_w;
  logic [CNT_W-1:0]                   r_cnt;
  logic [CYC_W-1:0]                   r_cyc;
  logic [IDX_W-1:0]                   r_cur, r_origin, r_step;
  logic                               r_detect;

  logic             w_stall, w_detect, w_has_org, w_has_nxt, w_last;
  logic [IDX_W-1:0] w_org, w_nxt;
  logic [1:0]       w_term;

  function automatic logic [IDX_W:0] f_lowest(input logic [PROC_NUM-1:0] v);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (v[i]) res = {1'b1, IDX_W'(i)};
    return res;
  endfunction

  assign w_stall  = (i_blocked_vec != '0) && (i_blocked_vec == r_prev_b);
  assign w_detect = (r_state == S_IDLE) && w_stall && (r_cnt == CNT_LAST);
  assign {w_has_org, w_org} = f_lowest(r_snap_b & ~r_done);
  assign {w_has_nxt, w_nxt} = f_lowest(r_snap_w[r_cur] & r_snap_b);

  // Termination priority: dead end, closed loop, merge/self-loop, step limit.
  always_comb begin
    w_last = 1'b1;
    w_term = 2'd1;
    if (!w_has_nxt) begin
      w_term = 2'd1;
    end else if (w_nxt == r_origin) begin
      w_term = 2'd0;
    end else if (w_nxt == r_cur || r_done[w_nxt]) begin
      w_term = 2'd2;
    end else if (r_step == STEP_LAST) begin
      w_term = 2'd3;
    end else begin
      w_last = 1'b0;
      w_term = 2'd0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    if (i_dl_clear) begin
      w_nstate = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_detect) w_nstate = S_SELECT;
        S_SELECT: w_nstate = w_has_org ? S_EMIT : S_DONE;
        S_EMIT:   if (i_rec_ready && w_last) w_nstate = S_SELECT;
        default:  w_nstate = S_DONE;
      endcase
    end
  end

  always_comb begin
    o_rec_valid    = (r_state == S_EMIT);
    o_report_done  = (r_state == S_DONE);
    o_rec_last     = (r_state == S_EMIT) && w_last;
    o_rec_term     = (r_state == S_EMIT) ? w_term : 2'd0;
    o_dl_detect    = r_detect;
    o_rec_cycle_id = r_cyc;
    o_rec_proc_idx = r_cur;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev_b <= '0;
      r_snap_b <= '0;
      r_snap_w <= '0;
      r_done   <= '0;
      r_cnt    <= '0;
      r_cyc    <= '0;
      r_cur    <= '0;
      r_origin <= '0;
      r_step   <= '0;
      r_detect <= 1'b0;
    end else begin
      r_prev_b <= i_blocked_vec;
      if (i_dl_clear) begin
        r_detect <= 1'b0;
        r_done   <= '0;
        r_cyc    <= '0;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_detect) begin
              r_snap_b <= i_blocked_vec;
              r_snap_w <= i_wait_for;
              r_detect <= 1'b1;
              r_cnt    <= '0;
            end else if (w_stall) begin
              if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt <= '0;
            end
          end
          S_SELECT: begin
            if (w_has_org) begin
              r_cyc    <= r_cyc + CYC_W'(1);
              r_cur    <= w_org;
              r_origin <= w_org;
              r_step   <= '0;
            end
          end
          S_EMIT: begin
            if (i_rec_ready) begin
              r_done[r_cur] <= 1'b1;
              if (!w_last) begin
                r_cur  <= w_nxt;
                r_step <= r_step + IDX_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DL_TRACE_TIMESTAMP_EN
  logic [31:0] r_tctr, r_tcap;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tctr <= '0;
      r_tcap <= '0;
    end else begin
      r_tctr <= r_tctr + 32'd1;
      if (!i_dl_clear && w_detect) r_tcap <= r_tctr;
    end
  end
  assign o_rec_time = r_tcap;
`endif

endmodule

// File: tb/tb_dl_cycle_tracer.sv
// Directed bench for dl_cycle_tracer: a slot-queue model predicts detection, records and done,
// and directed tests pin the model with hand-computed record lists.
`timescale 1ns/1ps
module tb_dl_cycle_tracer;
  localparam int P = 4, TH = 4, CW = 8, IW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic [P-1:0]   b   = '0;
  logic [P*P-1:0] wf  = '0;
  logic           clr = 1'b0, rdy = 1'b1;
  logic           det, vld, last, done;
  logic [CW-1:0]  cyc;
  logic [IW-1:0]  pidx;
  logic [1:0]     term;
`ifdef DL_TRACE_TIMESTAMP_EN
  logic [31:0]    rtime;
`endif

  dl_cycle_tracer #(.PROC_NUM(P), .STALL_THRESH(TH), .CYC_W(CW)) dut (
    .i_clock(clk), .i_reset(rst), .i_blocked_vec(b), .i_wait_for(wf),
    .i_dl_clear(clr), .o_dl_detect(det), .o_rec_valid(vld), .i_rec_ready(rdy),
    .o_rec_cycle_id(cyc), .o_rec_proc_idx(pidx), .o_rec_last(last), .o_rec_term(term),
`ifdef DL_TRACE_TIMESTAMP_EN
    .o_rec_time(rtime),
`endif
    .o_report_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {bit gap; int cyc; int proc; bit last; int term;} slot_t;
  slot_t q[$];
  slot_t acc[$];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected output stream after detection: a gap for every SELECT, then that walk's records.
  task automatic build(input logic [P-1:0] sb, input logic [P*P-1:0] sw);
    bit dn[P];
    int ncyc, org, cur, nxt, tm;
    bit lst;
    ncyc = 0;
    for (int i = 0; i < P; i++) dn[i] = 0;
    for (int g = 0; g <= P; g++) begin
      org = -1;
      for (int i = P - 1; i >= 0; i--) if (sb[i] && !dn[i]) org = i;
      if (org < 0) break;
      ncyc++;
      q.push_back('{1, 0, 0, 0, 0});
      cur = org;
      for (int s = 0; s < P; s++) begin
        nxt = -1;
        for (int j = P - 1; j >= 0; j--) if (sw[cur*P + j] && sb[j]) nxt = j;
        lst = 1; tm = 0;
        if (nxt < 0) tm = 1;
        else if (nxt == org) tm = 0;
        else if (nxt == cur || dn[nxt]) tm = 2;
        else if (s == P - 1) tm = 3;
        else lst = 0;
        q.push_back('{0, ncyc, cur, lst, tm});
        dn[cur] = 1;
        if (lst) break;
        cur = nxt;
      end
    end
    q.push_back('{1, 0, 0, 0, 0});
  endtask

  int m_eq, m_phase;
  bit m_det;
  logic [P-1:0] m_prev;
  logic [31:0] m_time, m_cap;
  bit p_ok, p_valid;
  logic [CW-1:0] p_cyc;
  logic [IW-1:0] p_proc;
  logic p_last;
  logic [1:0] p_term;

  always @(posedge clk) begin
    bit hs, stall;
    if (rst) begin
      m_eq = 0; m_phase = 0; m_det = 0; m_prev = '0; m_time = '0; m_cap = '0;
      q.delete();
      p_ok = 0;
    end else begin
      hs    = p_ok && p_valid && rdy && !clr;
      stall = p_ok && p_valid && !rdy && !clr;
      if (hs) acc.push_back('{0, int'(p_cyc), int'(p_proc), p_last, int'(p_term)});
      if (clr) begin
        m_phase = 0; m_eq = 0; m_det = 0;
        q.delete();
      end else if (m_phase == 0) begin
        if (b != '0 && b == m_prev) begin
          m_eq++;
          if (m_eq == TH) begin
            build(b, wf);
            m_phase = 1; m_det = 1; m_eq = 0; m_cap = m_time;
          end
        end else begin
          m_eq = 0;
        end
      end else if (m_phase == 1) begin
        if (q[0].gap || rdy) void'(q.pop_front());
        if (q.size() == 0) m_phase = 2;
      end
      m_prev = b;
      m_time = m_time + 32'd1;
      #1;
      chk("dl_detect", det, m_det);
      chk("rec_valid", vld, (m_phase == 1) && !q[0].gap);
      chk("report_done", done, m_phase == 2);
      if (m_phase == 1 && !q[0].gap) begin
        chk("rec_cycle_id", cyc, q[0].cyc);
        chk("rec_proc_idx", pidx, q[0].proc);
        chk("rec_last", last, q[0].last);
        if (q[0].last) chk("rec_term", term, q[0].term);
`ifdef DL_TRACE_TIMESTAMP_EN
        chk("rec_time", rtime, m_cap);
`endif
      end
      if (stall) begin
        chk("hold_valid", vld, 1);
        chk("hold_cycle_id", cyc, p_cyc);
        chk("hold_proc_idx", pidx, p_proc);
        chk("hold_last", last, p_last);
        chk("hold_term", term, p_term);
      end
      p_valid = vld; p_cyc = cyc; p_proc = pidx; p_last = last; p_term = term; p_ok = 1;
    end
  end

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      if (done) ok = 1;
    end
    chk({nm, "_done_reached"}, ok, 1);
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(posedge clk); #1;
      if (vld) ok = 1;
    end
    chk({nm, "_valid_reached"}, ok, 1);
  endtask

  task automatic clear_all();
    @(negedge clk); b = '0; wf = '0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clear_detect", det, 0);
    chk("clear_done", done, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_detect"}, det, 0);
    chk({nm, "_valid"}, vld, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_cycle_id"}, cyc, 0);
    chk({nm, "_proc_idx"}, pidx, 0);
    chk({nm, "_last"}, last, 0);
    chk({nm, "_term"}, term, 0);
  endtask

  initial begin
    int det_at;
    bit seen;
    #12;
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;

    // Single two-process loop: detection timing and record contents.
    @(negedge clk); b = 4'b0011; wf = 16'h0012; acc.delete();
    det_at = 0;
    for (int k = 1; k <= 20 && det_at == 0; k++) begin
      @(posedge clk); #1;
      if (det) det_at = k;
    end
    chk("t1_detect_edge", det_at, 5);
    wait_done("t1");
    chk("t1_nrec", acc.size(), 2);
    chk("t1_r0_id", acc[0].cyc, 1);
    chk("t1_r0_proc", acc[0].proc, 0);
    chk("t1_r0_last", acc[0].last, 0);
    chk("t1_r1_id", acc[1].cyc, 1);
    chk("t1_r1_proc", acc[1].proc, 1);
    chk("t1_r1_last", acc[1].last, 1);
    chk("t1_r1_term", acc[1].term, 0);
    clear_all();

    // Blocked vector changes every 3 cycles: stall window never fills.
    seen = 0;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk); b = (r % 2) ? 4'b0111 : 4'b0011;
      repeat (3) begin
        @(posedge clk); #1;
        if (det) seen = 1;
      end
    end
    chk("t2_no_detect", seen, 0);
    @(negedge clk); b = '0;
    repeat (2) @(negedge clk);

    // Two disjoint loops {0,1} and {2,3}.
    acc.delete();
    b = 4'b1111; wf = 16'h4812;
    wait_done("t3");
    chk("t3_nrec", acc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_id", acc[i].cyc, (i < 2) ? 1 : 2);
      chk("t3_proc", acc[i].proc, i);
      chk("t3_last", acc[i].last, i % 2);
    end
    chk("t3_term_a", acc[1].term, 0);
    chk("t3_term_b", acc[3].term, 0);
    clear_all();

    // Open chain 0->1->2, process 2 waits on nobody.
    acc.delete();
    b = 4'b0111; wf = 16'h0042;
    wait_done("t4");
    chk("t4_nrec", acc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_id", acc[i].cyc, 1);
      chk("t4_proc", acc[i].proc, i);
      chk("t4_last", acc[i].last, i == 2);
    end
    chk("t4_term", acc[2].term, 1);
    clear_all();

    // Backpressure hold, then clear while a record is pending.
    @(negedge clk); rdy = 1'b0; b = 4'b0011; wf = 16'h0012;
    wait_valid("t5");
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_still_valid", vld, 1);
    chk("t5_still_proc", pidx, 0);
    @(negedge clk); clr = 1'b1; b = '0; wf = '0;
    @(posedge clk); #1;
    chk("t5_clr_valid", vld, 0);
    chk("t5_clr_detect", det, 0);
    chk("t5_clr_cycle_id", cyc, 0);
    @(negedge clk); clr = 1'b0;

    // Asynchronous reset in the middle of a walk.
    @(negedge clk); b = 4'b0011; wf = 16'h0012;
    wait_valid("t6");
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk_zero("t6_async");
    b = '0; wf = '0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; rdy = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dl_cycle_tracer.md
Name: dl_cycle_tracer

Overview:
- Synthesizable, parametrised successor to the simulation-only deadlock report unit for dataflow regions.
- Watches per-process blocked flags and a wait-for matrix, and declares deadlock after a programmable stall window.
- Walks every dependence cycle or chain and streams one record per process over a valid/ready port.
- Sits beside the dataflow top; feeds a debug FIFO/UART or a testbench monitor.

Parameters:
- PROC_NUM, 4, number of monitored processes (>=2); IDX_W = $clog2(PROC_NUM) derived locally.
- STALL_THRESH, 16, consecutive identical non-zero blocked_vec cycles required to declare deadlock (>=1).
- CYC_W, 8, width of cycle id counter.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- blocked_vec  in  PROC_NUM  bit i = process i stalled on a channel/sync.
- wait_for  in  PROC_NUM*PROC_NUM  bits [i*PROC_NUM +: PROC_NUM] = processes i waits on.
- dl_clear  in  1  re-arm request.
- dl_detect  out  1  sticky high from detection until dl_clear/reset.
- rec_valid  out  1  record valid.
- rec_ready  in  1  record accepted when valid&ready.
- rec_cycle_id  out  CYC_W  cycle number, first = 1.
- rec_proc_idx  out  IDX_W  process index of this record.
- rec_last  out  1  final record of current cycle/chain.
- rec_term  out  2  termination code, valid with rec_last: 0 closed to origin, 1 no successor, 2 merges into reported proc or self-loop, 3 step limit.
- report_done  out  1  high in DONE state.

Behaviour:
- Reset (async, any state incl. mid-walk): FSM->IDLE; stall counter, snapshots, done mask, cycle id = 0; all outputs 0.
- States: IDLE, SELECT, EMIT, DONE.
- IDLE, stall detection:
  - prev_blocked registered each cycle.
  - If blocked_vec!=0 and ==prev_blocked, cnt++ (saturating); else cnt=0.
  - When cnt reaches STALL_THRESH-1 with the condition still true: next edge snapshots blocked_vec -> snap_b and wait_for -> snap_w, sets dl_detect, goes SELECT.
  - Net: dl_detect rises on the edge after STALL_THRESH+1 equal samples (first sample only loads prev).
- SELECT (1 cycle):
  - origin = lowest i with snap_b[i] & ~done[i].
  - None -> DONE.
  - Else cycle_id++, cur = origin, step = 0, -> EMIT.
- EMIT: rec_valid=1; rec_proc_idx=cur; rec_cycle_id held.
  - next = lowest j in snap_w[cur]&snap_b.
  - rec_last/rec_term combinational from registered state, priority:
    - no next -> 1.
    - next==origin -> 0.
    - next==cur or done[next] -> 2.
    - step==PROC_NUM-1 -> 3.
    - else rec_last=0.
  - On handshake: done[cur]=1. If rec_last -> SELECT, else cur=next, step++.
  - Outputs stay stable while rec_valid & ~rec_ready (no retraction).
- DONE: report_done=1, dl_detect=1, rec_valid=0; holds until dl_clear.
- dl_clear (any state, priority over all transitions): next edge -> IDLE.
  - Clears dl_detect, done mask, cycle_id, cnt, report_done.
  - Any pending record is dropped (rec_valid low next cycle).
- Live inputs are ignored after detection; only snapshots are used.
- cycle_id wraps modulo 2^CYC_W (cannot exceed PROC_NUM in practice).
- Total records per detection = popcount(snap_b).

Optional Feature:
- DL_TRACE_TIMESTAMP_EN defined:
  - Free-running 32-bit cycle counter, reset 0, wraps.
  - Extra output port rec_time (out, 32) = counter value captured at the detection edge, constant across all records until dl_clear.
- Undefined: counter and port are absent; all other behaviour is identical.

Test Plan:
- STALL_THRESH=4, blocked_vec=4'b0011 held, wait_for row0=0010, row1=0001 -> dl_detect high 5 edges after first sample.
  - Records (1,0,last0), (1,1,last1,term0), then report_done.
- blocked_vec toggles 0011/0111 every 3 cycles with threshold 4 -> dl_detect never asserts; counter resets on each change.
- Two disjoint cycles {0,1} and {2,3} on PROC_NUM=4 -> ids 1,1,2,2, procs 0,1,2,3, both last records term0.
- Chain: blocked=0111, 0->1, 1->2, 2 waits on none -> procs 0,1,2, last on 2 with term1. Then SELECT finds none -> DONE.
- rec_ready low 5 cycles mid-walk -> all rec_* fields stable. Then dl_clear during EMIT -> rec_valid 0, dl_detect 0, FSM IDLE next cycle.
- Async reset pulse mid-EMIT -> all outputs 0 immediately. With DL_TRACE_TIMESTAMP_EN, rec_time equals the counter at the detection edge for every record.
